// File: rtl/nyq_interp.sv
// nyq_interp: polyphase Nyquist interpolator. It takes one signed sample per
// L-cycle frame and emits L low-pass filtered samples, one per cycle.
//
// Ports:
//   Clk_CI, Rst_RBI (async, active-low)
//   WrEn_SI/Addr_DI/PAR_In_DI : coefficient memory write port
//                               (h[Addr] for Addr < TAPS, otherwise ignored)
//   Clr_SI                    : synchronous flush of delay line and frame
//   In_DI/In_Valid_SI/In_Ready_SO : sample input handshake
//   Out_DO/Out_Valid_DO       : registered filtered output
//
// Build option: define NYQ_INTERP_SAT_EN to saturate the output to
// OUT_WIDTH. Without it the output wraps (two's complement truncation).

module nyq_interp #(
    parameter int ADDR_WIDTH  = 9,
    parameter int MEM_WIDTH   = 32,
    parameter int COEFF_WIDTH = 16,
    parameter int IN_WIDTH    = 24,
    parameter int OUT_WIDTH   = 24,
    parameter int L           = 8,
    parameter int TAPS        = 32
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
    input  logic                  Clr_SI,
    input  logic [IN_WIDTH-1:0]   In_DI,
    input  logic                  In_Valid_SI,
    output logic                  In_Ready_SO,
    output logic [OUT_WIDTH-1:0]  Out_DO,
    output logic                  Out_Valid_DO
);

    localparam int K   = TAPS / L;
    localparam int PW  = $clog2(L);
    localparam int KW  = $clog2(K);
    localparam int TW  = PW + KW;
    localparam int PRW = IN_WIDTH + COEFF_WIDTH;
    localparam int ACW = PRW + KW;

    localparam logic [ADDR_WIDTH-1:0] TAPS_A  = ADDR_WIDTH'(TAPS);
    localparam logic [PW-1:0]         PH_LAST = PW'(L - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [COEFF_WIDTH-1:0] r_h [TAPS];
    logic signed [IN_WIDTH-1:0]    r_x [K];
    logic [PW-1:0]                 r_phase;
    logic [OUT_WIDTH-1:0]          r_out;
    logic                          r_out_vld;

    logic                          w_last;
    logic                          w_ready;
    logic                          w_accept;
    logic signed [PRW-1:0]         w_prod [K];
    logic signed [ACW-1:0]         w_acc;
    logic signed [ACW-1:0]         w_sh;
    logic [OUT_WIDTH-1:0]          w_res;
    logic                          w_unused;

    // Coefficient memory; out-of-range addresses are dropped, not aliased.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int i = 0; i < TAPS; i++) begin
                r_h[i] <= '0;
            end
        end else if (WrEn_SI && (Addr_DI < TAPS_A)) begin
            r_h[Addr_DI[TW-1:0]] <= PAR_In_DI[COEFF_WIDTH-1:0];
        end
    end

    assign w_last   = (r_phase == PH_LAST);
    assign w_ready  = (r_state == IDLE) || ((r_state == RUN) && w_last);
    assign w_accept = In_Valid_SI && w_ready;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last && !w_accept) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (Clr_SI) begin
            w_state_nxt = IDLE;
        end
    end

    // Phase p uses taps p, p+L, p+2L, ...; with L a power of two the
    // tap index is simply {k, phase}.
    always_comb begin
        w_acc = '0;
        for (int k = 0; k < K; k++) begin
            w_prod[k] = r_x[k] * r_h[{KW'(k), r_phase}];
            w_acc     = w_acc + {{KW{w_prod[k][PRW-1]}}, w_prod[k]};
        end
    end

    assign w_sh = w_acc >>> (COEFF_WIDTH - 1);

`ifdef NYQ_INTERP_SAT_EN
    localparam logic [OUT_WIDTH-1:0] OMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic w_ovf;

    // Out of range when the bits above the output sign are not all copies
    // of the accumulator sign.
    assign w_ovf = (w_sh[ACW-1:OUT_WIDTH-1]
                    != {(ACW-OUT_WIDTH+1){w_sh[ACW-1]}});
    assign w_res = !w_ovf     ? w_sh[OUT_WIDTH-1:0] :
                   w_sh[ACW-1] ? OMIN : OMAX;
`else
    assign w_res = w_sh[OUT_WIDTH-1:0];
`endif

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int k = 0; k < K; k++) begin
                r_x[k] <= '0;
            end
            r_phase   <= '0;
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else if (Clr_SI) begin
            for (int k = 0; k < K; k++) begin
                r_x[k] <= '0;
            end
            r_phase   <= '0;
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else begin
            if (r_state == RUN) begin
                r_out     <= w_res;
                r_out_vld <= 1'b1;
                r_phase   <= r_phase + 1'b1;
            end else begin
                r_out_vld <= 1'b0;
            end
            // The accept overrides the phase increment so a back-to-back
            // frame restarts at phase 0 without a bubble.
            if (w_accept) begin
                r_x[0] <= In_DI;
                for (int k = 1; k < K; k++) begin
                    r_x[k] <= r_x[k-1];
                end
                r_phase <= '0;
            end
        end
    end

    assign In_Ready_SO  = w_ready;
    assign Out_DO       = r_out;
    assign Out_Valid_DO = r_out_vld;

    assign w_unused = ^{PAR_In_DI[MEM_WIDTH-1:COEFF_WIDTH],
                        w_sh[ACW-1:OUT_WIDTH]};

endmodule

// File: tb/tb_nyq_interp.sv
// tb_nyq_interp: self-checking bench for nyq_interp.
// Table-driven impulse frames plus a queue scoreboard fed by a reference model.

module tb_nyq_interp;

    logic        Clk_CI;
    logic        Rst_RBI;
    logic        WrEn_SI;
    logic [8:0]  Addr_DI;
    logic [31:0] PAR_In_DI;
    logic        Clr_SI;
    logic [23:0] In_DI;
    logic        In_Valid_SI;
    logic        In_Ready_SO;
    logic [23:0] Out_DO;
    logic        Out_Valid_DO;

    nyq_interp dut (
        .Clk_CI       (Clk_CI),
        .Rst_RBI      (Rst_RBI),
        .WrEn_SI      (WrEn_SI),
        .Addr_DI      (Addr_DI),
        .PAR_In_DI    (PAR_In_DI),
        .Clr_SI       (Clr_SI),
        .In_DI        (In_DI),
        .In_Valid_SI  (In_Valid_SI),
        .In_Ready_SO  (In_Ready_SO),
        .Out_DO       (Out_DO),
        .Out_Valid_DO (Out_Valid_DO)
    );

    initial Clk_CI = 1'b0;
    always #5 Clk_CI = ~Clk_CI;

`ifdef NYQ_INTERP_SAT_EN
    localparam logic [23:0] OVF_EXP = 24'h7FFFFF;
`else
    localparam logic [23:0] OVF_EXP = 24'hFFFBFC;
`endif

    typedef struct packed {
        logic [23:0]      din;
        logic [7:0][23:0] exp;
    } vec_t;

    vec_t tbl [5];

    int total = 0;
    int bad   = 0;

    logic signed [15:0] hm [32];
    logic signed [23:0] xm [4];
    logic [23:0]        exp_q [$];

    int          run      = 0;
    int          last_run = 0;
    logic [23:0] last_out = '0;
    logic [23:0] last_exp = '0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic logic [23:0] model(input int p);
        longint acc;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            acc += longint'(hm[p + 8*k]) * longint'(xm[k]);
        end
        acc = acc >>> 15;
`ifdef NYQ_INTERP_SAT_EN
        if (acc > 64'sd8388607) acc = 64'sd8388607;
        else if (acc < -64'sd8388608) acc = -64'sd8388608;
`endif
        return acc[23:0];
    endfunction

    task automatic push_model();
        for (int p = 0; p < 8; p++) begin
            exp_q.push_back(model(p));
        end
    endtask

    // Output monitor: every valid output must match the head of the queue.
    always @(negedge Clk_CI) begin
        if (!Rst_RBI) begin
            run = 0;
        end else if (Out_Valid_DO) begin
            run++;
            last_out = Out_DO;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %h, required no output",
                         Out_DO);
            end else begin
                last_exp = exp_q.pop_front();
                check("out", {8'h0, Out_DO}, {8'h0, last_exp});
            end
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
    end

    task automatic wr_coef(input int a, input logic [31:0] v);
        @(negedge Clk_CI);
        WrEn_SI   = 1'b1;
        Addr_DI   = a[8:0];
        PAR_In_DI = v;
        @(posedge Clk_CI);
        if (a < 32) hm[a] = v[15:0];
        #1 WrEn_SI = 1'b0;
    endtask

    // Raise valid at a negedge and hold it until the DUT takes the sample.
    task automatic send(input logic [23:0] d);
        int n;
        n = 0;
        @(negedge Clk_CI);
        In_DI       = d;
        In_Valid_SI = 1'b1;
        while (!In_Ready_SO && n < 64) begin
            @(negedge Clk_CI);
            n++;
        end
        if (n >= 64) begin
            total++;
            bad++;
            $display("FAIL send_timeout: ready low %0d cycles, required <64", n);
        end
        @(posedge Clk_CI);
        for (int k = 3; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = d;
    endtask

    task automatic idle();
        @(negedge Clk_CI);
        In_Valid_SI = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge Clk_CI);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d outputs pending, required 0",
                     exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge Clk_CI);
    endtask

    task automatic clr();
        @(negedge Clk_CI);
        Clr_SI = 1'b1;
        @(posedge Clk_CI);
        for (int k = 0; k < 4; k++) xm[k] = '0;
        exp_q.delete();
        @(negedge Clk_CI);
        Clr_SI = 1'b0;
    endtask

    task automatic run_tbl();
        for (int f = 0; f < 5; f++) begin
            send(tbl[f].din);
            for (int p = 0; p < 8; p++) exp_q.push_back(tbl[f].exp[p]);
        end
        idle();
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int f = 0; f < 5; f++) begin
            tbl[f].din = (f == 0) ? 24'h040000 : 24'h000000;
            for (int p = 0; p < 8; p++) begin
                tbl[f].exp[p] = (f < 4) ? 24'((f*8 + p + 1) * 'h800) : 24'h0;
            end
        end
        for (int i = 0; i < 32; i++) hm[i] = '0;
        for (int k = 0; k < 4; k++) xm[k] = '0;

        Rst_RBI     = 1'b0;
        WrEn_SI     = 1'b0;
        Addr_DI     = '0;
        PAR_In_DI   = '0;
        Clr_SI      = 1'b0;
        In_DI       = '0;
        In_Valid_SI = 1'b0;
        repeat (3) @(posedge Clk_CI);
        @(negedge Clk_CI);
        Rst_RBI = 1'b1;
        @(negedge Clk_CI);
        check("rst_ready", {31'h0, In_Ready_SO}, 32'h1);
        check("rst_valid", {31'h0, Out_Valid_DO}, 32'h0);
        check("rst_out", {8'h0, Out_DO}, 32'h0);

        // Coefficients reset to zero: any sample gives zero output.
        send(24'h123456);
        push_model();
        idle();
        drain();

        // Impulse coefficients plus writes that must be ignored.
        for (int i = 0; i < 32; i++) wr_coef(i, 32'((i + 1) << 8));
        wr_coef(32, 32'hFFFF7FFF);
        wr_coef(40, 32'h00001234);
        wr_coef(511, 32'h0000ABCD);
        clr();
        run_tbl();
        check("tbl_tail_run", 32'(last_run), 32'd40);

        // Back-to-back: four frames with valid held high.
        for (int i = 0; i < 4; i++) begin
            send(24'($urandom));
            push_model();
        end
        idle();
        drain();
        check("b2b_run", 32'(last_run), 32'd32);

        // Gap: single sample then idle.
        send(24'($urandom));
        push_model();
        idle();
        drain();
        check("gap_run", 32'(last_run), 32'd8);
        check("gap_valid", {31'h0, Out_Valid_DO}, 32'h0);
        check("gap_ready", {31'h0, In_Ready_SO}, 32'h1);
        check("gap_hold", {8'h0, Out_DO}, {8'h0, last_exp});

        // Clear at phase 3 of an impulse frame.
        clr();
        send(24'h040000);
        for (int p = 0; p < 8; p++) exp_q.push_back(tbl[0].exp[p]);
        idle();
        repeat (3) @(posedge Clk_CI);
        clr();
        check("clr_valid", {31'h0, Out_Valid_DO}, 32'h0);
        check("clr_out", {8'h0, Out_DO}, 32'h0);
        check("clr_ready", {31'h0, In_Ready_SO}, 32'h1);
        @(negedge Clk_CI);
        check("clr_run", 32'(last_run), 32'd3);
        run_tbl();

        // Random signed coefficients and data.
        for (int i = 0; i < 32; i++) wr_coef(i, $urandom);
        for (int i = 0; i < 6; i++) begin
            send(24'($urandom));
            push_model();
        end
        idle();
        drain();

        // Overflow: full-scale coefficients and input.
        for (int i = 0; i < 32; i++) wr_coef(i, 32'h00007FFF);
        clr();
        for (int i = 0; i < 4; i++) begin
            send(24'h7FFFFF);
            push_model();
        end
        idle();
        drain();
        check("ovf_frame4", {8'h0, last_out}, {8'h0, OVF_EXP});
        for (int i = 0; i < 4; i++) begin
            send(24'h800000);
            push_model();
        end
        idle();
        drain();

        // Async reset in the middle of a frame.
        send(24'($urandom));
        push_model();
        idle();
        repeat (2) @(posedge Clk_CI);
        @(negedge Clk_CI);
        Rst_RBI = 1'b0;
        #1;
        check("arst_valid", {31'h0, Out_Valid_DO}, 32'h0);
        check("arst_out", {8'h0, Out_DO}, 32'h0);
        check("arst_ready", {31'h0, In_Ready_SO}, 32'h1);
        exp_q.delete();
        for (int i = 0; i < 32; i++) hm[i] = '0;
        for (int k = 0; k < 4; k++) xm[k] = '0;
        @(negedge Clk_CI);
        Rst_RBI = 1'b1;
        send(24'h040000);
        push_model();
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
